// File: rtl/disp_pkg.sv
// disp_pkg: shared widths, blank patterns, arbiter state encoding and an index helper.
`default_nettype none

package disp_pkg;

   localparam int DIGIT_W = 7;
   localparam int PAGE_W  = 28;
   localparam logic [DIGIT_W-1:0] SEG_BLANK  = 7'h7F;
   localparam logic [PAGE_W-1:0]  PAGE_BLANK = {(PAGE_W / DIGIT_W){SEG_BLANK}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHOW   = 2'd1,
      URGENT = 2'd2
   } disp_state_t;

   // Successor of idx in a ring of n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/disp_rr_pick.sv
// disp_rr_pick: combinational search for the first set request at or after start (wrapping).
`default_nettype none

module disp_rr_pick #(
   parameter int N_SRC = 4,
   parameter int AW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [AW-1:0]    start,
   output logic             found,
   output logic [AW-1:0]    index
);

   logic [AW-1:0] cand;

   // Walk offsets from the far end so the closest hit is written last.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int off = N_SRC - 1; off >= 0; off--) begin
         cand = AW'((int'(start) + off) % N_SRC);
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/disp_page_arbiter.sv
// disp_page_arbiter: round-robin display page sharing with a preemptive urgent page on source 0.
// Optional macro DISP_BLINK_EN makes the urgent page blink with half-period BLINK_CYCLES.
`default_nettype none

module disp_page_arbiter
   import disp_pkg::*;
#(
   parameter int N_SRC        = 4,
   parameter int DWELL_CYCLES = 200000000,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N_SRC-1:0]          req_i,
   input  logic [PAGE_W*N_SRC-1:0]   data_i,
   input  logic                      urgent_i,
   output logic [PAGE_W-1:0]         number_o,
   output logic [$clog2(N_SRC)-1:0]  active_o,
   output logic                      valid_o,
   output logic [N_SRC-1:0]          ack_o
);

   localparam int AW = $clog2(N_SRC);
   localparam int CW = $clog2(DWELL_CYCLES);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

   disp_state_t   state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] rr_ptr;

   logic [PAGE_W-1:0] pages [N_SRC];
   logic [PAGE_W-1:0] urgent_page;
   logic              urgent_req, go_urgent, urgent_hold, advance, pick_found;
   logic [AW-1:0]     pick_start, pick_idx, after_active;

   for (genvar k = 0; k < N_SRC; k++) begin : g_page
      assign pages[k] = data_i[k*PAGE_W +: PAGE_W];
   end

   assign urgent_req   = urgent_i & req_i[0];
   assign go_urgent    = urgent_req && (state != URGENT);
   assign urgent_hold  = urgent_req && (state == URGENT);
   assign after_active = AW'(wrap_inc(int'(active_o), N_SRC));

   // Expiry and request drop share one search so a coincident pair advances once.
   always_comb begin
      pick_start = after_active;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            pick_start = rr_ptr;
            advance    = 1'b1;
         end
         SHOW:    advance = !req_i[active_o] || (cnt == DWELL_LAST);
         URGENT: begin
            pick_start = AW'(1);
            advance    = !urgent_req;
         end
         default: advance = 1'b1;
      endcase
   end

   disp_rr_pick #(
      .N_SRC (N_SRC),
      .AW    (AW)
   ) u_pick (
      .req   (req_i),
      .start (pick_start),
      .found (pick_found),
      .index (pick_idx)
   );

`ifdef DISP_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_off, blink_off_nxt;

   assign blink_off_nxt = (blink_cnt == BLINK_LAST) ? ~blink_off : blink_off;
   assign urgent_page   = blink_off_nxt ? PAGE_BLANK : pages[0];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || !urgent_hold) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end
`else
   assign urgent_page = pages[0];
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         cnt      <= '0;
         rr_ptr   <= '0;
         active_o <= '0;
         valid_o  <= 1'b0;
         ack_o    <= '0;
         number_o <= PAGE_BLANK;
      end else begin
         ack_o <= '0;
         if (go_urgent) begin
            state    <= URGENT;
            cnt      <= '0;
            rr_ptr   <= AW'(1);
            active_o <= '0;
            valid_o  <= 1'b1;
            ack_o    <= N_SRC'(1);
            number_o <= pages[0];
         end else if (urgent_hold) begin
            cnt      <= '0;
            number_o <= urgent_page;
         end else if (advance && pick_found) begin
            state    <= SHOW;
            cnt      <= '0;
            rr_ptr   <= AW'(wrap_inc(int'(pick_idx), N_SRC));
            active_o <= pick_idx;
            valid_o  <= 1'b1;
            ack_o    <= N_SRC'(1) << pick_idx;
            number_o <= pages[pick_idx];
         end else if (advance) begin
            state    <= IDLE;
            cnt      <= '0;
            valid_o  <= 1'b0;
            number_o <= PAGE_BLANK;
         end else begin
            cnt      <= cnt + 1'b1;
            number_o <= pages[active_o];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_disp_page_arbiter.sv
// tb_disp_page_arbiter: directed vector table, corner sequences and a randomized model comparison.
`default_nettype none

module tb_disp_page_arbiter;

   localparam int N     = 4;
   localparam int DWELL = 8;
   localparam int BLINK = 4;
   localparam logic [27:0] BLANK = 28'hFFFFFFF;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic [N-1:0] req_i;
   logic         urgent_i;
   logic [27:0]  data [N];
   logic [28*N-1:0] data_i;
   logic [27:0]  number_o;
   logic [1:0]   active_o;
   logic         valid_o;
   logic [N-1:0] ack_o;

   int n_chk  = 0;
   int n_fail = 0;

   assign data_i = {data[3], data[2], data[1], data[0]};

   always #5 clk = ~clk;

   disp_page_arbiter #(
      .N_SRC        (N),
      .DWELL_CYCLES (DWELL),
      .BLINK_CYCLES (BLINK)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .data_i   (data_i),
      .urgent_i (urgent_i),
      .number_o (number_o),
      .active_o (active_o),
      .valid_o  (valid_o),
      .ack_o    (ack_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic ev, input int ea, input logic [N-1:0] eack,
                           input logic [27:0] enum_v, input bit chk_act, input bit chk_num);
      chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
      chk({tag, ".ack"}, 32'(ack_o), 32'(eack));
      if (chk_act) chk({tag, ".active"}, 32'(active_o), 32'(ea));
      if (chk_num) chk({tag, ".number"}, 32'(number_o), 32'(enum_v));
   endtask

   // ---------------- reference model ----------------
   int m_mode, m_act, m_age, m_rr, m_ack, m_uage;   // mode: 0 idle, 1 page shown, 2 urgent

   function automatic int find_from(input logic [N-1:0] r, input int s);
      for (int d = 0; d < N; d++) begin
         if (r[(s + d) % N]) return (s + d) % N;
      end
      return -1;
   endfunction

   task automatic model_step(input logic rn, input logic [N-1:0] r, input logic u);
      int w;
      m_ack = -1;
      if (!rn) begin
         m_mode = 0; m_act = 0; m_age = 0; m_rr = 0; m_uage = 0;
      end else if (u && r[0]) begin
         if (m_mode != 2) begin
            m_mode = 2; m_act = 0; m_age = 0; m_uage = 0; m_ack = 0; m_rr = 1;
         end else begin
            m_uage++;
         end
      end else if (m_mode == 0 || m_mode == 2 || !r[m_act] || m_age == DWELL - 1) begin
         w = (m_mode == 0) ? find_from(r, m_rr) : find_from(r, m_act + 1);
         if (w < 0) begin
            m_mode = 0; m_age = 0;
         end else begin
            m_mode = 1; m_act = w; m_age = 0; m_ack = w; m_rr = (w + 1) % N;
         end
      end else begin
         m_age++;
      end
   endtask

   function automatic logic [27:0] model_number();
      if (m_mode == 0) return BLANK;
`ifdef DISP_BLINK_EN
      if (m_mode == 2 && ((m_uage / BLINK) % 2) == 1) return BLANK;
`endif
      return data[m_act];
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic         rn;
      logic [N-1:0] req;
      logic         urg;
      int           n;
      logic         ev;
      int           ea;
      logic [N-1:0] eack;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rn, input logic [N-1:0] r, input logic u, input int n,
                      input logic ev, input int ea, input logic [N-1:0] eack);
      vec_t v;
      v.rn = rn; v.req = r; v.urg = u; v.n = n; v.ev = ev; v.ea = ea; v.eack = eack;
      tbl.push_back(v);
   endtask

   initial begin
      logic [27:0] en;
      bit          cn;
      rst_ni   = 1'b0;
      req_i    = '0;
      urgent_i = 1'b0;
      for (int k = 0; k < N; k++) data[k] = 28'h1111111 * 28'(k + 1);

      add(0, 4'b0000, 0, 2, 0, 0, 4'b0000);
      add(1, 4'b0101, 0, 1, 1, 0, 4'b0001);
      add(1, 4'b0101, 0, 7, 1, 0, 4'b0000);
      add(1, 4'b0101, 0, 1, 1, 2, 4'b0100);
      add(1, 4'b0101, 0, 7, 1, 2, 4'b0000);
      add(1, 4'b0101, 0, 1, 1, 0, 4'b0001);
      add(1, 4'b0101, 0, 7, 1, 0, 4'b0000);
      add(1, 4'b0101, 0, 1, 1, 2, 4'b0100);
      add(1, 4'b0110, 0, 7, 1, 2, 4'b0000);
      add(1, 4'b0110, 0, 1, 1, 1, 4'b0010);
      add(1, 4'b0110, 0, 2, 1, 1, 4'b0000);
      add(1, 4'b0100, 0, 1, 1, 2, 4'b0100);
      add(1, 4'b0000, 0, 1, 0, 0, 4'b0000);
      add(1, 4'b1000, 0, 1, 1, 3, 4'b1000);
      add(1, 4'b1000, 0, 7, 1, 3, 4'b0000);
      add(1, 4'b1000, 0, 1, 1, 3, 4'b1000);
      add(1, 4'b0101, 0, 1, 1, 0, 4'b0001);
      add(1, 4'b0100, 0, 1, 1, 2, 4'b0100);
      add(1, 4'b0111, 1, 1, 1, 0, 4'b0001);
      add(1, 4'b0111, 1, 50, 1, 0, 4'b0000);
      add(1, 4'b0111, 0, 1, 1, 1, 4'b0010);
      add(1, 4'b0110, 1, 7, 1, 1, 4'b0000);
      add(1, 4'b0110, 1, 1, 1, 2, 4'b0100);
      add(1, 4'b0110, 0, 3, 1, 2, 4'b0000);
      add(0, 4'b0110, 0, 1, 0, 0, 4'b0000);
      add(1, 4'b0000, 0, 1, 0, 0, 4'b0000);

      foreach (tbl[i]) begin
         rst_ni   = tbl[i].rn;
         req_i    = tbl[i].req;
         urgent_i = tbl[i].urg;
         for (int c = 0; c < tbl[i].n; c++) begin
            tick();
            en = tbl[i].ev ? data[tbl[i].ea] : BLANK;
            cn = 1'b1;
`ifdef DISP_BLINK_EN
            if (tbl[i].urg && tbl[i].req[0]) cn = 1'b0;
`endif
            chk_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eack, en,
                     tbl[i].ev || !tbl[i].rn, cn);
         end
      end

      // live data update propagates within one cycle
      req_i = 4'b1000;
      tick();
      chk("live.active", 32'(active_o), 32'd3);
      chk("live.before", 32'(number_o), 32'(data[3]));
      data[3] = 28'h0123456;
      tick();
      chk("live.after", 32'(number_o), 32'h0123456);

      // urgent coinciding with dwell expiry
      rst_ni = 1'b0; req_i = '0; urgent_i = 1'b0;
      tick();
      rst_ni = 1'b1; req_i = 4'b0101;
      tick();
      chk("ue.start_ack", 32'(ack_o), 32'b0001);
      repeat (DWELL - 1) tick();
      urgent_i = 1'b1;
      tick();
      chk("ue.active", 32'(active_o), 32'd0);
      chk("ue.ack", 32'(ack_o), 32'b0001);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("ue.hold_ack", 32'(ack_o), 32'b0000);
      end
      urgent_i = 1'b0;
      tick();
      chk("ue.exit_active", 32'(active_o), 32'd2);
      chk("ue.exit_ack", 32'(ack_o), 32'b0100);

      // request drop coinciding with expiry of the same source
      repeat (DWELL - 1) tick();
      req_i = 4'b0001;
      tick();
      chk("de.active", 32'(active_o), 32'd0);
      chk("de.ack", 32'(ack_o), 32'b0001);
      tick();
      chk("de.single", 32'(ack_o), 32'b0000);
      chk("de.active2", 32'(active_o), 32'd0);

`ifdef DISP_BLINK_EN
      rst_ni = 1'b0; req_i = '0; urgent_i = 1'b0;
      tick();
      rst_ni = 1'b1; req_i = 4'b0001; urgent_i = 1'b1;
      tick();
      for (int i = 0; i < 4 * BLINK; i++) begin
         chk("blink.valid", 32'(valid_o), 32'd1);
         chk("blink.number", 32'(number_o), 32'((((i / BLINK) % 2) == 0) ? data[0] : BLANK));
         tick();
      end
      urgent_i = 1'b0;
`endif

      // randomized comparison against the reference model
      urgent_i = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst_ni = (c < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 5) == 0) req_i = 4'($urandom);
         if ($urandom_range(0, 19) == 0) urgent_i = ~urgent_i;
         if ($urandom_range(0, 3) == 0) data[$urandom_range(0, N - 1)] = 28'($urandom);
         model_step(rst_ni, req_i, urgent_i);
         tick();
         chk_outs("rand", m_mode != 0, m_act, (m_ack >= 0) ? (N'(1) << m_ack) : '0,
                  model_number(), (m_mode != 0) || !rst_ni, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
